// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stage register: slot-state enum and default NOP payloads.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slot_state_e;

    // All-zero payload decodes as RegWrite = 0, PCSrc = NPC_PLUS4 in the packed stage formats.
    localparam int          NOP_W       = 32;
    localparam logic [31:0] NOP_PAYLOAD = 32'h0000_0000;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid flag plus payload register with clear-to-NOP, load and hold.
module pipe_slot #(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  NOP_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic              vld,
    output logic [DATA_W-1:0] q
);

    // Clear wins over load so a flush always drops a beat offered in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            vld <= 1'b0;
            q   <= NOP_VAL;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready, flush and NOP bubbles.
// Define PIPE_SKID_BUFFER_EN for a two-slot skid buffer with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

`ifdef PIPE_SKID_BUFFER_EN
    slot_state_e       state, nxt;
    logic              rdy_q;
    logic              main_clr, main_ld, skid_clr, skid_ld;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] main_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= nxt;
            rdy_q <= (nxt != FULL);
        end
    end

    always_comb begin
        nxt      = state;
        main_clr = flush;
        main_ld  = 1'b0;
        skid_clr = flush;
        skid_ld  = 1'b0;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (xfer_in) begin
                    nxt     = ONE;
                    main_ld = 1'b1;
                end
                ONE: begin
                    if (xfer_in && !xfer_out) begin
                        nxt     = FULL;
                        skid_ld = 1'b1;
                    end else if (!xfer_in && xfer_out) begin
                        nxt      = EMPTY;
                        main_clr = 1'b1;
                    end else if (xfer_in) begin
                        main_ld = 1'b1;
                    end
                end
                FULL: if (xfer_out) begin
                    nxt      = ONE;
                    main_ld  = 1'b1;
                    skid_clr = 1'b1;
                end
                default: nxt = EMPTY;
            endcase
        end
    end

    // The skid beat is always older than anything upstream, so it refills main first.
    assign main_d   = skid_vld ? skid_q : in_data;
    assign in_ready = rdy_q & ~flush;
    assign occ      = state;

    pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
        .clk(clk), .rst(rst), .clr(main_clr), .load(main_ld),
        .d(main_d), .vld(out_valid), .q(out_data)
    );

    pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_skid (
        .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_ld),
        .d(in_data), .vld(skid_vld), .q(skid_q)
    );
`else
    logic main_clr;

    assign in_ready = ~flush & (~out_valid | out_ready);
    assign main_clr = flush | (xfer_out & ~xfer_in);
    assign occ      = {1'b0, out_valid};

    pipe_slot #(.DATA_W(DATA_W), .NOP_VAL(NOP_VAL)) u_main (
        .clk(clk), .rst(rst), .clr(main_clr), .load(xfer_in),
        .d(in_data), .vld(out_valid), .q(out_data)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a queue of held beats predicts every output each cycle.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occ;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb[$];       // beats held by the stage, oldest first
    bit          rdy_reg = 1'b1;

    pipe_stage_reg #(.DATA_W(32), .NOP_VAL(32'h0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .occ(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive after negedge, check just before posedge, then advance the model.
    task automatic step(input bit r, input bit iv, input logic [31:0] id,
                        input bit ordy, input bit fl, input bit do_chk);
        bit exp_rdy, popped, accepted;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = fl ? 1'b0 : (SKID ? rdy_reg : (sb.size() == 0 || ordy));
        if (do_chk) begin
            if (r) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
            chk("out_data", out_data, (sb.size() != 0) ? sb[0] : NOP);
            chk("occ", {30'b0, occ}, sb.size());
        end
        if (!r || fl) begin
            sb.delete();
            rdy_reg = 1'b1;
        end else begin
            popped   = ordy && sb.size() != 0;
            accepted = iv && exp_rdy;
            if (popped) void'(sb.pop_front());
            if (accepted) sb.push_back(id);
            rdy_reg = sb.size() < 2;
        end
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

        // Reset with a beat offered: nothing may be captured.
        step(0, 1, 32'hDEADBEEF, 0, 0, 0);
        step(0, 1, 32'hDEADBEEF, 0, 0, 1);
        step(1, 0, 32'h0, 0, 0, 1);

        // Streaming 1..8 at full rate, then drain.
        for (int i = 1; i <= 8; i++) step(1, 1, i, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);

        // Stall with B6 pending, release, drain.
        step(1, 1, 32'hA5, 1, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 32'hB6, 0, 0, 1);
        step(1, 1, 32'hB6, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);

        // Fill, then flush with C7 offered: C7 must never appear.
        step(1, 1, 32'h11, 0, 0, 1);
        step(1, 1, 32'h22, 0, 0, 1);
        step(1, 1, 32'hC7, 0, 1, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);

        // Simultaneous transfers with one beat resident.
        step(1, 1, 32'h100, 1, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, 1, 32'h100 + i, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);

        // Reset arriving mid-stall.
        step(1, 1, 32'h33, 0, 0, 1);
        step(1, 1, 32'h44, 0, 0, 1);
        step(0, 1, 32'h55, 0, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);

        // Mixed traffic.
        for (int i = 0; i < 60; i++)
            step(1, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);
        step(1, 0, 32'h0, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with valid/ready flow control, synchronous flush and bubble insertion. It generalises the fixed-field inter-stage latches (IF/ID … MEM/WB) into one reusable stage: the payload is a flat DATA_W vector packed by the instantiating stage, and the block adds stall back-pressure, NOP bubbles and an optional skid buffer that breaks the ready path. It sits between any two pipeline stages of the CPU.

## Interface
- DATA_W, 32: payload width in bits; any value ≥ 1.
- NOP_VAL, {DATA_W{1'b0}}: payload presented while no beat is held. This is the bubble value: RegWrite = 0 and PCSrc = NPC_PLUS4 in the packed form.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- in_valid  in  1  upstream has a beat on in_data.
- in_ready  out  1  stage accepts a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  synchronous kill of all held beats (branch or exception squash).
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream consumes the beat this cycle.
- out_data  out  DATA_W  registered payload.
- occ  out  2  number of held beats (0..1, or 0..2 with skid).

## Operation
- Transfer in: in_valid & in_ready at posedge. Transfer out: out_valid & out_ready at posedge.
- Priority at each posedge: rst low, then flush, then normal transfer.
- Reset or flush:
  - every slot becomes invalid;
  - out_data = NOP_VAL, occ = 0;
  - any beat offered in the same cycle is dropped;
  - in_ready is forced 0 combinationally while flush = 1.
- Base mode (single slot):
  - in_ready = !out_valid | out_ready.
  - On transfer in, the slot loads in_data and out_valid becomes 1.
  - On transfer out with no transfer in, out_valid becomes 0 and out_data loads NOP_VAL.
  - A simultaneous transfer in and out replaces the slot; out_valid stays 1.
- out_data never changes while out_valid & !out_ready (stall holds the beat stable).
- The payload is opaque. It is never inspected or modified.

## Timing
- Latency: 1 cycle from in_data to out_data.
- Throughput: 1 beat per cycle while out_ready = 1.
- Base mode has a combinational path from out_ready to in_ready.
- Reset values: out_valid = 0, out_data = NOP_VAL, occ = 0. in_ready = 1 in the first cycle after reset, provided flush = 0.
- A flush that arrives while downstream stalls still clears the held beat. The beat is not delivered.
- A reset that arrives mid-stall discards all data; nothing is partially transferred.

## Configuration
- PIPE_SKID_BUFFER_EN defined: two slots, main and skid, with a registered in_ready and no combinational out_ready-to-in_ready path. State machine:
  - EMPTY: transfer in goes to ONE.
  - ONE, transfer in without transfer out: the beat goes to skid; next state FULL.
  - ONE, transfer out without transfer in: next state EMPTY.
  - ONE, both transfers: main is replaced; state stays ONE.
  - FULL: in_ready = 0. On transfer out, skid moves to main; next state ONE.
  - in_ready is registered as (next_state != FULL).
  - occ = 0, 1 or 2 for EMPTY, ONE or FULL.
  - Order is preserved: the main beat is always older than the skid beat.
- PIPE_SKID_BUFFER_EN undefined: base single-slot behaviour; occ[1] is tied to 0.

## Structure
- Shared package pipe_pkg holds:
  - state encoding: EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2;
  - the default NOP payload constants used by the stage wrappers.
- NPC_PLUS4 remains in ENCODE.v.
- One natural sub-module, pipe_slot: a valid flag plus a DATA_W data register with load, clear-to-NOP_VAL and hold controls. It is instantiated once in base mode and twice with skid.

## Test plan
- Reset: hold rst = 0 for 2 cycles with in_valid = 1 and in_data = 32'hDEADBEEF -> out_valid = 0, out_data = NOP_VAL, occ = 0. in_ready = 1 after rst = 1.
- Streaming: out_ready = 1 with beats 1..8 on consecutive cycles -> out_data shows 1..8 one cycle later; there are no gaps.
- Stall: beat 32'hA5 is accepted, then out_ready = 0 for 3 cycles while in_valid = 1 with 32'hB6 -> out_data stays A5 for 3 cycles.
  - Base mode: in_ready = 0 throughout.
  - Skid mode: B6 is accepted into skid, occ = 2, in_ready = 0 next cycle.
  - On release, the output order is A5 then B6.
- Flush: occ = 2 (skid mode) and flush = 1 with in_valid = 1 and data 32'hC7 -> next cycle occ = 0 and out_data = NOP_VAL; C7 never appears.
- Simultaneous transfers: occ = 1 and in_valid = out_ready = 1 every cycle for 10 cycles -> occ stays 1; each beat appears exactly once.
- Drain: after a stall releases -> out_valid falls exactly when the last beat is consumed, and out_data returns to NOP_VAL the same cycle.
